// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scanner for a common-anode 4-digit 7-segment display.
// Digits are snapshotted on load; each slot opens with a blanked guard cycle.
module seven_seg_scanner #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] digits,
   input  logic        load,
   input  logic        blank_lz,
   input  logic [3:0]  dp_mask,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame
);

   localparam int               DIV_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   logic [15:0]      r_hold;
   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_slot;
   logic             r_guard;
   logic [3:0]       r_an;
   logic [6:0]       r_seg;
   logic             r_dp;
   logic             r_frame;

   logic             w_wrap;
   logic [3:0]       w_digit;
   logic             w_blank;
   logic [6:0]       w_seg_dec;
   logic [3:0]       w_an_nxt;
   logic [6:0]       w_seg_nxt;
   logic             w_dp_nxt;
   logic             w_z3;
   logic             w_z2;
   logic             w_z1;

   assign w_wrap = (r_div == DIV_LAST);
   assign w_z3   = (r_hold[15:12] == 4'd0);
   assign w_z2   = (r_hold[11:8]  == 4'd0);
   assign w_z1   = (r_hold[7:4]   == 4'd0);

   always_comb begin
      w_digit = r_hold[3:0];
      w_blank = 1'b0;
      case (r_slot)
         2'd0: begin
            w_digit = r_hold[3:0];
            w_blank = 1'b0;
         end
         2'd1: begin
            w_digit = r_hold[7:4];
            w_blank = blank_lz & w_z3 & w_z2 & w_z1;
         end
         2'd2: begin
            w_digit = r_hold[11:8];
            w_blank = blank_lz & w_z3 & w_z2;
         end
         default: begin
            w_digit = r_hold[15:12];
            w_blank = blank_lz & w_z3;
         end
      endcase
   end

   // Active-low {g,f,e,d,c,b,a}; codes above 9 show a dash.
   always_comb begin
      w_seg_dec = 7'b0111111;
      case (w_digit)
         4'd0:    w_seg_dec = 7'b1000000;
         4'd1:    w_seg_dec = 7'b1111001;
         4'd2:    w_seg_dec = 7'b0100100;
         4'd3:    w_seg_dec = 7'b0110000;
         4'd4:    w_seg_dec = 7'b0011001;
         4'd5:    w_seg_dec = 7'b0010010;
         4'd6:    w_seg_dec = 7'b0000010;
         4'd7:    w_seg_dec = 7'b1111000;
         4'd8:    w_seg_dec = 7'b0000000;
         4'd9:    w_seg_dec = 7'b0010000;
         default: w_seg_dec = 7'b0111111;
      endcase
   end

   always_comb begin
      w_an_nxt  = 4'b1111;
      w_seg_nxt = 7'b1111111;
      w_dp_nxt  = 1'b1;
      if (!r_guard) begin
         w_an_nxt  = ~(4'b0001 << r_slot);
         w_seg_nxt = w_blank ? 7'b1111111 : w_seg_dec;
         w_dp_nxt  = ~dp_mask[r_slot];
      end
   end

   // Guard is set on every slot change and out of reset, so it tracks r_div == 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hold  <= 16'd0;
         r_div   <= '0;
         r_slot  <= 2'd0;
         r_guard <= 1'b1;
         r_an    <= 4'b1111;
         r_seg   <= 7'b1111111;
         r_dp    <= 1'b1;
         r_frame <= 1'b0;
      end else begin
         if (load) begin
            r_hold <= digits;
         end
         if (w_wrap) begin
            r_div  <= '0;
            r_slot <= r_slot + 2'd1;
         end else begin
            r_div  <= r_div + DIV_W'(1);
         end
         r_guard <= w_wrap;
         r_frame <= w_wrap && (r_slot == 2'd3);
         r_an    <= w_an_nxt;
         r_seg   <= w_seg_nxt;
         r_dp    <= w_dp_nxt;
      end
   end

   assign an    = r_an;
   assign seg   = r_seg;
   assign dp    = r_dp;
   assign frame = r_frame;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with REFRESH_DIV = 4 (16-cycle frame).
module tb_seven_seg_scanner;

   logic        clk;
   logic        reset_n;
   logic [15:0] digits;
   logic        load;
   logic        blank_lz;
   logic [3:0]  dp_mask;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [6:0] S0    = 7'b1000000;
   localparam logic [6:0] S1    = 7'b1111001;
   localparam logic [6:0] S2    = 7'b0100100;
   localparam logic [6:0] S3    = 7'b0110000;
   localparam logic [6:0] S4    = 7'b0011001;
   localparam logic [6:0] S5    = 7'b0010010;
   localparam logic [6:0] S8    = 7'b0000000;
   localparam logic [6:0] SDASH = 7'b0111111;
   localparam logic [6:0] SOFF  = 7'b1111111;

   seven_seg_scanner #(.REFRESH_DIV(4)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .digits   (digits),
      .load     (load),
      .blank_lz (blank_lz),
      .dp_mask  (dp_mask),
      .an       (an),
      .seg      (seg),
      .dp       (dp),
      .frame    (frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int k, input logic [3:0] e_an,
                      input logic [6:0] e_seg, input logic e_dp, input logic e_fr);
      n_assert++;
      assert (an === e_an) else begin
         n_fail++;
         $error("FAIL %s[%0d] an: observed %b expected %b", tag, k, an, e_an);
      end
      n_assert++;
      assert (seg === e_seg) else begin
         n_fail++;
         $error("FAIL %s[%0d] seg: observed %b expected %b", tag, k, seg, e_seg);
      end
      n_assert++;
      assert (dp === e_dp) else begin
         n_fail++;
         $error("FAIL %s[%0d] dp: observed %b expected %b", tag, k, dp, e_dp);
      end
      n_assert++;
      assert (frame === e_fr) else begin
         n_fail++;
         $error("FAIL %s[%0d] frame: observed %b expected %b", tag, k, frame, e_fr);
      end
   endtask

   // One aligned 16-cycle frame. s = {seg3,seg2,seg1,seg0}; m = expected lit dp slots.
   // If load_at > 0, digits = lv is loaded by the edge that produces cycle load_at.
   task automatic scan(input string tag, input logic [27:0] s, input logic [3:0] m,
                       input int load_at, input logic [15:0] lv);
      logic [3:0] one;
      int         slot;
      one = 4'b0001;
      for (int k = 1; k <= 16; k++) begin
         if (k == load_at) begin
            digits = lv;
            load   = 1'b1;
         end
         @(posedge clk);
         #1;
         load = 1'b0;
         slot = (k - 1) / 4;
         if (((k - 1) % 4) == 0)
            chk(tag, k, 4'b1111, SOFF, 1'b1, k == 16);
         else
            chk(tag, k, ~(one << slot), s[slot*7 +: 7], ~m[slot], k == 16);
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      digits   = 16'hFFFF;
      load     = 1'b1;
      blank_lz = 1'b0;
      dp_mask  = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      chk("reset", 0, 4'b1111, SOFF, 1'b1, 1'b0);

      // Load held high during reset must not reach the hold registers.
      @(negedge clk);
      reset_n = 1'b1;
      load    = 1'b0;
      digits  = 16'h0000;
      scan("zeros", {S0, S0, S0, S0}, 4'b0000, 0, 16'h0000);

      scan("d1234", {S1, S2, S3, S4}, 4'b0000, 1, 16'h1234);

      blank_lz = 1'b1;
      scan("d0050_blank", {SOFF, SOFF, S5, S0}, 4'b0000, 1, 16'h0050);

      blank_lz = 1'b0;
      scan("d0050_noblank", {S0, S0, S5, S0}, 4'b0000, 0, 16'h0000);

      blank_lz = 1'b1;
      dp_mask  = 4'b0100;
      scan("d00A0_dp", {SOFF, SOFF, SDASH, S0}, 4'b0100, 1, 16'h00A0);

      dp_mask = 4'b0000;
      digits  = 16'h9876;
      scan("no_load", {SOFF, SOFF, SDASH, S0}, 4'b0000, 0, 16'h0000);

      // Load on the edge that wraps into slot 2: slots 0/1 show old, 2/3 new.
      scan("load_wrap2", {SOFF, S8, SDASH, S0}, 4'b0000, 8, 16'h0800);

      // Reset between edges while frame is high.
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_reset", 0, 4'b1111, SOFF, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      chk("held_reset", 0, 4'b1111, SOFF, 1'b1, 1'b0);
      blank_lz = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      scan("after_reset", {S0, S0, S0, S0}, 4'b0000, 0, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
